// File: rtl/seq_divider_32bit.sv
// Purpose: radix-2 restoring integer divider (signed/unsigned) with RISC-V M divide-by-zero/overflow results.
// Latency: WIDTH+1 cycles from the start edge to done (1 cycle for divide by zero); one op in flight.
// Backpressure: none; start is honoured only in IDLE, otherwise ignored; results hold until the next completion.
module seq_divider_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder (always < divisor magnitude)
    logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend magnitude, shifts out MSB-first while quotient bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // The shifted partial remainder plus the trial subtraction are WIDTH+1 bits wide;
    // the top bit of the trial result is the borrow that decides restore vs keep.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Next-state, datapath iteration and result formatting.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        done_d        = 1'b0;

        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed & dividend[WIDTH-1];
                    dvs_d     = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (divisor == '0) begin
                        // Raw dividend is kept so it can be returned unchanged as the remainder.
                        dbz_d   = 1'b1;
                        dvd_d   = dividend;
                        state_d = S_FIX;
                    end else begin
                        dbz_d   = 1'b0;
                        dvd_d   = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                // Divide by zero bypasses sign correction; overflow needs no special case.
                quotient_d    = dbz_q ? '1 : (neg_quo_q ? -dvd_q : dvd_q);
                remainder_d   = dbz_q ? dvd_q : (neg_rem_q ? -rem_q : rem_q);
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC);
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Purpose: self-checking bench for seq_divider_32bit: directed corner cases plus randomized ops against a model.
// Latency: expects done 33 edges after the start edge (1 edge for divide by zero), busy high 32 cycles.
// Backpressure: exercises ignored start while busy, back-to-back start in the done cycle, and mid-op reset.
module tb_seq_divider_32bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks;
    int failures;

    seq_divider_32bit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero, RISC-V divide-by-zero rule.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb, sq, sr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Presents a request for exactly one edge, then scrambles the operand inputs.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    // Waits (bounded) for done; n counts negedges after the start edge, so latency in edges is n-1.
    task automatic wait_done(input int inject_at, output int lat, output int bcnt,
                             output int ovl, output int chg);
        logic [31:0] q0, r0;
        logic        z0;
        int          n;
        bit          got;
        q0 = quotient; r0 = remainder; z0 = div_by_zero;
        n = 0; got = 0; bcnt = 0; ovl = 0; chg = 0; lat = -1;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (n == inject_at) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
            end else if (inject_at != 0 && n == inject_at + 1) begin
                start = 1'b0;
            end
            if (busy) bcnt++;
            if (busy && done) ovl++;
            if (done) begin
                got = 1;
                lat = n - 1;
            end else if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) begin
                chg++;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] eq, input logic [31:0] er,
                                input logic ez, input int lat, input int bcnt,
                                input int ovl, input int chg);
        chk({tag, ".quotient"},  quotient, eq);
        chk({tag, ".remainder"}, remainder, er);
        chk({tag, ".dbz"},       32'(div_by_zero), 32'(ez));
        chk({tag, ".latency"},   lat,  ez ? 32'd1 : 32'd33);
        chk({tag, ".busy_cyc"},  bcnt, ez ? 32'd0 : 32'd32);
        chk({tag, ".busy_done_overlap"}, ovl, 32'd0);
        chk({tag, ".early_change"},      chg, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input logic ez);
        int lat, bc, ov, ch;
        @(negedge clk);
        launch(a, b, s);
        wait_done(0, lat, bc, ov, ch);
        check_result(tag, eq, er, ez, lat, bc, ov, ch);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, bc, ov, ch, quiet;
        logic [31:0] ra, rb, mq, mr;
        logic        rs, mz;
        int          mode;

        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset.quotient",  quotient, 32'd0);
        chk("reset.remainder", remainder, 32'd0);
        chk("reset.busy",      32'(busy), 32'd0);
        chk("reset.done",      32'(done), 32'd0);
        chk("reset.dbz",       32'(div_by_zero), 32'd0);

        // Directed cases.
        run_op("u100div7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0);
        run_op("s-100div7",   32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0);
        run_op("uMaxdiv2",    32'hFFFF_FFFF,  32'd2,          1'b0, 32'h7FFF_FFFF,  32'd1,          1'b0);
        run_op("u5div0",      32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1);
        run_op("s5div0",      32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1);
        run_op("sNeg5div0",   32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1);
        run_op("s_overflow",  32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0);
        run_op("s7div-2",     32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        launch(32'd100, 32'd7, 1'b0);
        wait_done(5, lat, bc, ov, ch);
        check_result("ignore_busy_start", 32'd14, 32'd2, 1'b0, lat, bc, ov, ch);
        launch(32'd9, 32'd3, 1'b0);
        wait_done(0, lat, bc, ov, ch);
        check_result("back_to_back", 32'd3, 32'd0, 1'b0, lat, bc, ov, ch);
        @(negedge clk);
        chk("back_to_back.done_pulse", 32'(done), 32'd0);

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 7));
            case (mode)
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, mq, mr, mz);
            run_op($sformatf("rand%0d", i), ra, rb, rs, mq, mr, mz);
        end

        // Mid-operation reset: outputs clear at once and no done pulse follows.
        @(negedge clk);
        launch(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset.quotient",  quotient, 32'd0);
        chk("midreset.remainder", remainder, 32'd0);
        chk("midreset.busy",      32'(busy), 32'd0);
        chk("midreset.done",      32'(done), 32'd0);
        chk("midreset.dbz",       32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        quiet = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) quiet++;
        end
        chk("midreset.no_done", quiet, 32'd0);
        run_op("after_reset_20div6", 32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
